// File: rtl/merge_pass_sched.sv
// Merge-pass scheduler: issues ping-pong merge jobs, doubling run length each pass.
// Ports: clock/reset, start + stream_len_in/src_bank_in, merge_req_* job handshake,
//   merge_done completion pulse, busy/done/result_bank/pass_cnt status.
module merge_pass_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int INIT_RUN   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   stream_len_in,
  input  logic                  src_bank_in,
  output logic                  merge_req_valid,
  input  logic                  merge_req_ready,
  output logic                  merge_src_bank,
  output logic [ADDR_WIDTH:0]   merge_a_addr,
  output logic [ADDR_WIDTH:0]   merge_a_len,
  output logic [ADDR_WIDTH:0]   merge_b_addr,
  output logic [ADDR_WIDTH:0]   merge_b_len,
  input  logic                  merge_done,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank,
  output logic [ADDR_WIDTH:0]   pass_cnt
);

  localparam int OW = ADDR_WIDTH + 1;
  localparam int IW = ADDR_WIDTH + 2;
  localparam logic [IW-1:0] INIT_RUN_W = IW'(INIT_RUN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_len;
  logic [IW-1:0] r_run;
  logic [IW-1:0] r_base;
  logic          r_src;

  logic          r_valid;
  logic          r_job_bank;
  logic [OW-1:0] r_a_addr;
  logic [OW-1:0] r_a_len;
  logic [OW-1:0] r_b_addr;
  logic [OW-1:0] r_b_len;
  logic          r_busy;
  logic          r_done;
  logic          r_result_bank;
  logic [OW-1:0] r_pass_cnt;

  logic [IW-1:0] w_rem_a;
  logic [IW-1:0] w_a_len;
  logic [IW-1:0] w_b_addr;
  logic [IW-1:0] w_rem_b;
  logic [IW-1:0] w_b_len;
  logic [IW-1:0] w_next_base;
  logic          w_fin;
  logic          w_accept;

  // Job geometry for the current base; in SETUP base < len always holds,
  // so the remaining counts never underflow when they are used.
  always_comb begin
    w_rem_a     = r_len - r_base;
    w_a_len     = (r_run < w_rem_a) ? r_run : w_rem_a;
    w_b_addr    = r_base + r_run;
    w_rem_b     = r_len - w_b_addr;
    w_b_len     = '0;
    if (w_b_addr < r_len) begin
      w_b_len   = (r_run < w_rem_b) ? r_run : w_rem_b;
    end
    w_next_base = r_base + (r_run << 1);
    w_fin       = (r_len <= r_run);
    w_accept    = start &&
                  ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_run         <= '0;
      r_base        <= '0;
      r_src         <= 1'b0;
      r_valid       <= 1'b0;
      r_job_bank    <= 1'b0;
      r_a_addr      <= '0;
      r_a_len       <= '0;
      r_b_addr      <= '0;
      r_b_len       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result_bank <= 1'b0;
      r_pass_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_len      <= {1'b0, stream_len_in};
            r_src      <= src_bank_in;
            r_run      <= INIT_RUN_W;
            r_base     <= '0;
            r_pass_cnt <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_fin) begin
            r_result_bank <= r_src;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_DONE;
          end else begin
            r_job_bank <= r_src;
            r_a_addr   <= r_base[OW-1:0];
            r_a_len    <= w_a_len[OW-1:0];
            r_b_addr   <= w_b_addr[OW-1:0];
            r_b_len    <= w_b_len[OW-1:0];
            r_valid    <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (merge_req_ready) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (merge_done) begin
            r_state <= S_ADV;
          end
        end
        S_ADV: begin
          if (w_next_base < r_len) begin
            r_base <= w_next_base;
          end else begin
            // Pass complete: output of this pass becomes next source.
            r_base     <= '0;
            r_run      <= r_run << 1;
            r_src      <= ~r_src;
            r_pass_cnt <= r_pass_cnt + OW'(1);
          end
          r_state <= S_SETUP;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign merge_req_valid = r_valid;
  assign merge_src_bank  = r_job_bank;
  assign merge_a_addr    = r_a_addr;
  assign merge_a_len     = r_a_len;
  assign merge_b_addr    = r_b_addr;
  assign merge_b_len     = r_b_len;
  assign busy            = r_busy;
  assign done            = r_done;
  assign result_bank     = r_result_bank;
  assign pass_cnt        = r_pass_cnt;

endmodule

// File: tb/tb_merge_pass_sched.sv
// Bench for merge_pass_sched: table cases, backpressure/reset sequence,
// and random lengths checked against a pass/job list model.
module tb_merge_pass_sched;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   stream_len_in;
  logic          src_bank_in;
  logic          merge_req_valid;
  logic          merge_req_ready;
  logic          merge_src_bank;
  logic [AW:0]   merge_a_addr;
  logic [AW:0]   merge_a_len;
  logic [AW:0]   merge_b_addr;
  logic [AW:0]   merge_b_len;
  logic          merge_done;
  logic          busy;
  logic          done;
  logic          result_bank;
  logic [AW:0]   pass_cnt;

  always #5 clock = ~clock;

  merge_pass_sched #(.ADDR_WIDTH(AW), .INIT_RUN(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stream_len_in(stream_len_in),
    .src_bank_in(src_bank_in),
    .merge_req_valid(merge_req_valid),
    .merge_req_ready(merge_req_ready),
    .merge_src_bank(merge_src_bank),
    .merge_a_addr(merge_a_addr),
    .merge_a_len(merge_a_len),
    .merge_b_addr(merge_b_addr),
    .merge_b_len(merge_b_len),
    .merge_done(merge_done),
    .busy(busy),
    .done(done),
    .result_bank(result_bank),
    .pass_cnt(pass_cnt)
  );

  typedef struct {
    int bank;
    int aa;
    int al;
    int ba;
    int bl;
  } job_t;

  typedef struct {
    int len;
    int src;
    int rpct;
    int dly;
    int jobs;
    int passes;
    int rb;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  job_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Every pass walks the stream in pairs of runs; stop once one run covers it.
  task automatic build_model(input int len, input int src,
                             output int passes, output int rb);
    int   run;
    int   s;
    job_t j;
    run    = 32;
    s      = src;
    passes = 0;
    exp_q.delete();
    while (len > run) begin
      for (int b = 0; b < len; b += 2 * run) begin
        j.bank = s;
        j.aa   = b;
        j.al   = imin(run, len - b);
        j.ba   = b + run;
        j.bl   = (b + run >= len) ? 0 : imin(run, len - b - run);
        exp_q.push_back(j);
      end
      s = 1 - s;
      passes++;
      run *= 2;
    end
    rb = s;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(merge_req_valid), 0);
    chk({tag, "_bank"},  int'(merge_src_bank), 0);
    chk({tag, "_aaddr"}, int'(merge_a_addr), 0);
    chk({tag, "_alen"},  int'(merge_a_len), 0);
    chk({tag, "_baddr"}, int'(merge_b_addr), 0);
    chk({tag, "_blen"},  int'(merge_b_len), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_rbank"}, int'(result_bank), 0);
    chk({tag, "_pass"},  int'(pass_cnt), 0);
  endtask

  task automatic chk_job(input string tag, input job_t e);
    chk({tag, "_bank"},  int'(merge_src_bank), e.bank);
    chk({tag, "_aaddr"}, int'(merge_a_addr), e.aa);
    chk({tag, "_alen"},  int'(merge_a_len), e.al);
    chk({tag, "_baddr"}, int'(merge_b_addr), e.ba);
    chk({tag, "_blen"},  int'(merge_b_len), e.bl);
  endtask

  task automatic run_case(input int len, input int src, input int rpct,
                          input int dlo, input int dhi, input int tj,
                          input int tp, input int trb, input bit use_tbl);
    int   mp;
    int   mrb;
    int   n0;
    int   njobs;
    int   dcnt;
    bit   stall;
    bit   fin;
    bit   rdy;
    job_t e;
    job_t sav;
    build_model(len, src, mp, mrb);
    n0    = exp_q.size();
    njobs = 0;
    dcnt  = 0;
    stall = 1'b0;
    fin   = 1'b0;
    @(negedge clock);
    stream_len_in = len[AW:0];
    src_bank_in   = src[0];
    start         = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge clock);
      start      = 1'b0;
      merge_done = 1'b0;
      if (cyc == 1) begin
        chk("lat1_busy", int'(busy), 1);
        chk("lat1_done", int'(done), 0);
        chk("lat1_valid", int'(merge_req_valid), 0);
      end
      if (cyc == 2) begin
        chk("lat2_valid", int'(merge_req_valid), (n0 > 0) ? 1 : 0);
        chk("lat2_done", int'(done), (n0 > 0) ? 0 : 1);
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) merge_done = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
      end else if (merge_req_valid) begin
        if (stall) chk_job("stable", sav);
        sav.bank = int'(merge_src_bank);
        sav.aa   = int'(merge_a_addr);
        sav.al   = int'(merge_a_len);
        sav.ba   = int'(merge_b_addr);
        sav.bl   = int'(merge_b_len);
        rdy      = ($urandom_range(99) < rpct);
        merge_req_ready = rdy;
        stall    = !rdy;
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_job", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk_job("job", e);
          end
          njobs++;
          dcnt = $urandom_range(dhi, dlo);
        end
      end else begin
        merge_req_ready = 1'($urandom_range(1));
        stall = 1'b0;
      end
    end
    merge_req_ready = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("job_count", njobs, use_tbl ? tj : n0);
    chk("passes", int'(pass_cnt), use_tbl ? tp : mp);
    chk("result_bank", int'(result_bank), use_tbl ? trb : mrb);
    chk("busy_done", int'(busy), 0);
    chk("model_left", exp_q.size(), 0);
    @(negedge clock);
    chk("done_hold", int'(done), 1);
  endtask

  initial begin
    bit got;
    job_t j0;
    int vp;
    int vrb;
    tbl[0] = '{len: 0,    src: 0, rpct: 100, dly: 10, jobs: 0,  passes: 0, rb: 0};
    tbl[1] = '{len: 32,   src: 1, rpct: 100, dly: 10, jobs: 0,  passes: 0, rb: 1};
    tbl[2] = '{len: 64,   src: 0, rpct: 100, dly: 10, jobs: 1,  passes: 1, rb: 1};
    tbl[3] = '{len: 100,  src: 0, rpct: 100, dly: 10, jobs: 3,  passes: 2, rb: 0};
    tbl[4] = '{len: 96,   src: 0, rpct: 60,  dly: 3,  jobs: 3,  passes: 2, rb: 0};
    tbl[5] = '{len: 33,   src: 1, rpct: 50,  dly: 1,  jobs: 1,  passes: 1, rb: 0};
    tbl[6] = '{len: 65,   src: 0, rpct: 70,  dly: 2,  jobs: 3,  passes: 2, rb: 0};
    tbl[7] = '{len: 1024, src: 1, rpct: 80,  dly: 1,  jobs: 31, passes: 5, rb: 0};

    reset           = 1'b1;
    start           = 1'b0;
    stream_len_in   = '0;
    src_bank_in     = 1'b0;
    merge_req_ready = 1'b0;
    merge_done      = 1'b0;
    repeat (3) @(negedge clock);
    chk_zero("rst");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_case(tbl[i].len, tbl[i].src, tbl[i].rpct, tbl[i].dly, tbl[i].dly,
               tbl[i].jobs, tbl[i].passes, tbl[i].rb, 1'b1);
    end

    // Backpressure, ignored start/merge_done, then reset while in WAIT.
    build_model(64, 0, vp, vrb);
    j0 = exp_q.pop_front();
    @(negedge clock);
    stream_len_in = 11'd64;
    src_bank_in   = 1'b0;
    start         = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      got = merge_req_valid;
    end
    chk("bp_valid_seen", int'(got), 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      chk("bp_valid", int'(merge_req_valid), 1);
      chk("bp_busy", int'(busy), 1);
      chk_job("bp", j0);
      start      = (k == 1);
      merge_done = (k == 2);
      if (k == 1) begin
        stream_len_in = 11'd500;
        src_bank_in   = 1'b1;
      end
    end
    merge_req_ready = 1'b1;
    @(negedge clock);
    merge_req_ready = 1'b0;
    chk("bp_drop", int'(merge_req_valid), 0);
    chk("bp_wait_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_zero("mid_rst");
    run_case(100, 0, 100, 10, 10, 3, 2, 0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      run_case($urandom_range(1024), int'($urandom_range(1)),
               $urandom_range(100, 30), 1, $urandom_range(6, 1),
               0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
